controle_nivel: RTL

Automatic tank-level controller that drives the valve's automatic command inputs (`abre_auto`, `fecha_auto`). It filters a sampled level reading against a low/high hysteresis band and issues single-cycle open/close command pulses. It enforces a minimum dwell between commands and a maximum fill time with a latched alarm. It stands down while the operator holds the valve in manual mode and resynchronises the valve when manual mode is released.

---
 rtl/controle_nivel.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/controle_nivel.sv
// controle_nivel: automatic tank-level controller issuing one-cycle open/close
// pulses to the valve, with hysteresis debounce, command dwell, fill timeout and alarm.
`default_nettype none

module controle_nivel #(
  parameter int LARGURA   = 8,
  parameter int NIVEL_MIN = 64,
  parameter int NIVEL_MAX = 192,
  parameter int DEBOUNCE  = 4,
  parameter int TEMPO_MIN = 16,
  parameter int TEMPO_MAX = 1000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               manual,
  input  logic [LARGURA-1:0] nivel,
  input  logic               valido,
  input  logic               reconhece,
  output logic               abre_auto,
  output logic               fecha_auto,
  output logic               enchendo,
  output logic               alarme
);

  localparam int WD = $clog2(DEBOUNCE + 1);
  localparam int WM = $clog2(TEMPO_MIN + 1);
  localparam int WT = $clog2(TEMPO_MAX + 1);

  localparam logic [LARGURA-1:0] LIM_BAIXO = LARGURA'(NIVEL_MIN);
  localparam logic [LARGURA-1:0] LIM_ALTO  = LARGURA'(NIVEL_MAX);
  localparam logic [WD-1:0]      DEB_FIM   = WD'(DEBOUNCE);
  localparam logic [WM-1:0]      DWELL_FIM = WM'(TEMPO_MIN);
  localparam logic [WT-1:0]      TIMER_FIM = WT'(TEMPO_MAX);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ENCHENDO = 2'd1,
    FALHA    = 2'd2
  } estado_t;

  estado_t       estado;
  logic [WD-1:0] cnt_baixo;
  logic [WD-1:0] cnt_alto;
  logic [WM-1:0] dwell;
  logic [WT-1:0] timer;
  logic          manual_d;

  logic amostra_baixa;
  logic amostra_alta;
  logic baixo_ok;
  logic alto_ok;
  logic dwell_ok;
  logic limpa_cnt;

  assign amostra_baixa = (nivel < LIM_BAIXO);
  assign amostra_alta  = (nivel >= LIM_ALTO);
  assign baixo_ok      = (cnt_baixo == DEB_FIM);
  assign alto_ok       = (cnt_alto == DEB_FIM);
  assign dwell_ok      = (dwell == DWELL_FIM);
  assign limpa_cnt     = (estado == FALHA) && reconhece && !manual;

  // Debounce counters: a sample of one class clears the other; in-band clears both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_baixo <= '0;
      cnt_alto  <= '0;
    end else if (manual || limpa_cnt) begin
      cnt_baixo <= '0;
      cnt_alto  <= '0;
    end else if (valido) begin
      if (amostra_baixa) begin
        cnt_baixo <= baixo_ok ? cnt_baixo : cnt_baixo + WD'(1);
        cnt_alto  <= '0;
      end else if (amostra_alta) begin
        cnt_alto  <= alto_ok ? cnt_alto : cnt_alto + WD'(1);
        cnt_baixo <= '0;
      end else begin
        cnt_baixo <= '0;
        cnt_alto  <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= PARADO;
      abre_auto  <= 1'b0;
      fecha_auto <= 1'b0;
      enchendo   <= 1'b0;
      alarme     <= 1'b0;
      timer      <= '0;
      dwell      <= DWELL_FIM;
      manual_d   <= 1'b0;
    end else begin
      manual_d   <= manual;
      abre_auto  <= 1'b0;
      fecha_auto <= 1'b0;
      if (!dwell_ok)
        dwell <= dwell + WM'(1);

      if (manual) begin
        // Operator owns the valve: hold state and timer, issue nothing.
      end else if (manual_d && estado != FALHA) begin
        // Manual just released: drive the valve closed so both sides agree.
        fecha_auto <= 1'b1;
        estado     <= PARADO;
        enchendo   <= 1'b0;
        dwell      <= '0;
      end else begin
        case (estado)
          PARADO: begin
            if (baixo_ok && dwell_ok) begin
              abre_auto <= 1'b1;
              estado    <= ENCHENDO;
              enchendo  <= 1'b1;
              timer     <= '0;
              dwell     <= '0;
            end
          end
          ENCHENDO: begin
            if (alto_ok && dwell_ok) begin
              fecha_auto <= 1'b1;
              estado     <= PARADO;
              enchendo   <= 1'b0;
              dwell      <= '0;
            end else if (timer == TIMER_FIM) begin
              // Fault close bypasses the dwell rule.
              fecha_auto <= 1'b1;
              estado     <= FALHA;
              enchendo   <= 1'b0;
              alarme     <= 1'b1;
              dwell      <= '0;
            end else begin
              timer <= timer + WT'(1);
            end
          end
          FALHA: begin
            if (reconhece) begin
              estado <= PARADO;
              alarme <= 1'b0;
            end
          end
          default: begin
            estado   <= PARADO;
            enchendo <= 1'b0;
            alarme   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
